// File: rtl/axi4_router_pkg.sv
// -----------------------------------------------------------------------------
// axi4_router_pkg
// Shared types for the AXI4 response router.
//   resp_e        : AXI response codes (OKAY/EXOKAY/SLVERR/DECERR)
//   track_entry_t : one outstanding-transaction table entry {valid, id, master}
// The id/master fields are sized to fixed maximums so one struct type serves
// every parameterisation; narrower values are zero-extended when stored.
// -----------------------------------------------------------------------------
package axi4_router_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    localparam int ENTRY_ID_W  = 16;
    localparam int ENTRY_MST_W = 8;

    typedef struct packed {
        logic                   valid;
        logic [ENTRY_ID_W-1:0]  id;
        logic [ENTRY_MST_W-1:0] master;
    } track_entry_t;

endpackage

// File: rtl/axi4_id_track_table.sv
// -----------------------------------------------------------------------------
// axi4_id_track_table
// Outstanding-transaction table: allocates the lowest free entry, looks up a
// response ID combinationally, frees the matching entry and keeps a count.
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   alloc_valid_i/master_i/id_i     allocation request
//   alloc_ready_o                   not full and alloc ID not already in use
//   lookup_id_i                     response ID to look up
//   match_o, match_master_o         lookup hit and owning master
//   free_i                          free the matching entry (ignored on miss)
//   count_o                         number of valid entries
// -----------------------------------------------------------------------------
module axi4_id_track_table
    import axi4_router_pkg::*;
#(
    parameter int ID_WIDTH    = 4,
    parameter int TABLE_DEPTH = 8,
    parameter int CNT_WIDTH   = $clog2(TABLE_DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   alloc_valid_i,
    input  logic [ENTRY_MST_W-1:0] alloc_master_i,
    input  logic [ID_WIDTH-1:0]    alloc_id_i,
    output logic                   alloc_ready_o,
    input  logic [ID_WIDTH-1:0]    lookup_id_i,
    output logic                   match_o,
    output logic [ENTRY_MST_W-1:0] match_master_o,
    input  logic                   free_i,
    output logic [CNT_WIDTH-1:0]   count_o
);

    localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;

    track_entry_t         entries_q [TABLE_DEPTH];
    track_entry_t         entries_d [TABLE_DEPTH];
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [IDX_W-1:0]     free_idx, match_idx;
    logic                 has_free, dup_id, alloc_fire, free_fire;

    // Scan from the top down so the lowest free index wins. The ID-in-use
    // check looks only at registered entries, so an ID freed this cycle
    // still stalls its re-allocation until the next cycle.
    always_comb begin
        has_free       = 1'b0;
        free_idx       = '0;
        dup_id         = 1'b0;
        match_o        = 1'b0;
        match_idx      = '0;
        match_master_o = '0;
        for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            if (entries_q[i].valid && entries_q[i].id == ENTRY_ID_W'(alloc_id_i)) begin
                dup_id = 1'b1;
            end
            if (entries_q[i].valid && entries_q[i].id == ENTRY_ID_W'(lookup_id_i)) begin
                match_o        = 1'b1;
                match_idx      = IDX_W'(i);
                match_master_o = entries_q[i].master;
            end
        end
    end

    assign alloc_ready_o = has_free && !dup_id;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign free_fire     = free_i && match_o;
    assign count_o       = count_q;

    // The freed slot is always a valid entry and the allocated slot an
    // invalid one, so both can be updated in the same cycle without conflict.
    always_comb begin
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (free_fire && match_idx == IDX_W'(i)) begin
                entries_d[i].valid = 1'b0;
            end
            if (alloc_fire && free_idx == IDX_W'(i)) begin
                entries_d[i].valid  = 1'b1;
                entries_d[i].id     = ENTRY_ID_W'(alloc_id_i);
                entries_d[i].master = alloc_master_i;
            end
        end
        count_d = count_q + CNT_WIDTH'(alloc_fire) - CNT_WIDTH'(free_fire);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi4_resp_router.sv
// -----------------------------------------------------------------------------
// axi4_resp_router
// Routes slave-side AXI responses back to the master that issued the request,
// using an ID tracking table filled at arbiter-grant time.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   alloc_valid/master/id, alloc_ready   grant-time table allocation
//   rsp_valid/id/resp/last, rsp_ready    incoming response
//   m_rsp_valid[], m_rsp_ready[]         per-master handshake
//   m_rsp_id/resp/last                   shared payload to all masters
//   outstanding                     valid table entries
//   unmatched_count                 saturating count of unmatched responses
// -----------------------------------------------------------------------------
module axi4_resp_router
    import axi4_router_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ID_WIDTH    = 4,
    parameter int TABLE_DEPTH = 8,
    localparam int MST_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int CNT_W      = $clog2(TABLE_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alloc_valid,
    input  logic [MST_W-1:0]       alloc_master,
    input  logic [ID_WIDTH-1:0]    alloc_id,
    output logic                   alloc_ready,
    input  logic                   rsp_valid,
    input  logic [ID_WIDTH-1:0]    rsp_id,
    input  logic [1:0]             rsp_resp,
    input  logic                   rsp_last,
    output logic                   rsp_ready,
    output logic [NUM_MASTERS-1:0] m_rsp_valid,
    output logic [ID_WIDTH-1:0]    m_rsp_id,
    output logic [1:0]             m_rsp_resp,
    output logic                   m_rsp_last,
    input  logic [NUM_MASTERS-1:0] m_rsp_ready,
    output logic [CNT_W-1:0]       outstanding,
    output logic [31:0]            unmatched_count
);

    logic                   match;
    logic [ENTRY_MST_W-1:0] match_master;
    logic                   sel_ready, rsp_fire;

    logic                   out_valid_q, out_valid_d;
    logic [ENTRY_MST_W-1:0] out_master_q, out_master_d;
    logic [ID_WIDTH-1:0]    out_id_q, out_id_d;
    logic [1:0]             out_resp_q, out_resp_d;
    logic                   out_last_q, out_last_d;
    logic [31:0]            unmatched_q, unmatched_d;

    axi4_id_track_table #(
        .ID_WIDTH    (ID_WIDTH),
        .TABLE_DEPTH (TABLE_DEPTH),
        .CNT_WIDTH   (CNT_W)
    ) u_table (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .alloc_valid_i  (alloc_valid),
        .alloc_master_i (ENTRY_MST_W'(alloc_master)),
        .alloc_id_i     (alloc_id),
        .alloc_ready_o  (alloc_ready),
        .lookup_id_i    (rsp_id),
        .match_o        (match),
        .match_master_o (match_master),
        .free_i         (rsp_fire && rsp_last),
        .count_o        (outstanding)
    );

    // Ready of the master currently addressed by the output register, plus
    // one-hot decode of the registered master onto the per-master valids.
    always_comb begin
        sel_ready   = 1'b0;
        m_rsp_valid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (out_master_q == ENTRY_MST_W'(i)) begin
                sel_ready      = m_rsp_ready[i];
                m_rsp_valid[i] = out_valid_q;
            end
        end
    end

    assign rsp_ready       = !out_valid_q || sel_ready;
    assign rsp_fire        = rsp_valid && rsp_ready;
    assign m_rsp_id        = out_id_q;
    assign m_rsp_resp      = out_resp_q;
    assign m_rsp_last      = out_last_q;
    assign unmatched_count = unmatched_q;

    // The payload only reloads on an accepted matching response, which can
    // happen only when the register is empty or draining, so it stays stable
    // while the selected master stalls.
    always_comb begin
        out_valid_d  = out_valid_q && !sel_ready;
        out_master_d = out_master_q;
        out_id_d     = out_id_q;
        out_resp_d   = out_resp_q;
        out_last_d   = out_last_q;
        unmatched_d  = unmatched_q;
        if (rsp_fire && match) begin
            out_valid_d  = 1'b1;
            out_master_d = match_master;
            out_id_d     = rsp_id;
            out_resp_d   = rsp_resp;
            out_last_d   = rsp_last;
        end
        if (rsp_fire && !match && unmatched_q != 32'hFFFF_FFFF) begin
            unmatched_d = unmatched_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_master_q <= '0;
            out_id_q     <= '0;
            out_resp_q   <= '0;
            out_last_q   <= 1'b0;
            unmatched_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_master_q <= out_master_d;
            out_id_q     <= out_id_d;
            out_resp_q   <= out_resp_d;
            out_last_q   <= out_last_d;
            unmatched_q  <= unmatched_d;
        end
    end

endmodule

// File: tb/tb_axi4_resp_router.sv
// -----------------------------------------------------------------------------
// tb_axi4_resp_router
// Directed bench for axi4_resp_router. Expected forwarded responses are queued
// when issued; a negedge monitor pops and compares each delivered response.
// -----------------------------------------------------------------------------
module tb_axi4_resp_router;
    import axi4_router_pkg::*;

    localparam int NM  = 4;
    localparam int IDW = 4;
    localparam int TD  = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           alloc_valid;
    logic [1:0]     alloc_master;
    logic [IDW-1:0] alloc_id;
    logic           alloc_ready;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [1:0]     rsp_resp;
    logic           rsp_last;
    logic           rsp_ready;
    logic [NM-1:0]  m_rsp_valid;
    logic [IDW-1:0] m_rsp_id;
    logic [1:0]     m_rsp_resp;
    logic           m_rsp_last;
    logic [NM-1:0]  m_rsp_ready;
    logic [3:0]     outstanding;
    logic [31:0]    unmatched_count;

    typedef struct {
        int master;
        int id;
        int resp;
        int last;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   assertCount = 0;
    int   failCount   = 0;

    always #5 clk = ~clk;

    axi4_resp_router #(
        .NUM_MASTERS (NM),
        .ID_WIDTH    (IDW),
        .TABLE_DEPTH (TD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_valid     (alloc_valid),
        .alloc_master    (alloc_master),
        .alloc_id        (alloc_id),
        .alloc_ready     (alloc_ready),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_resp        (rsp_resp),
        .rsp_last        (rsp_last),
        .rsp_ready       (rsp_ready),
        .m_rsp_valid     (m_rsp_valid),
        .m_rsp_id        (m_rsp_id),
        .m_rsp_resp      (m_rsp_resp),
        .m_rsp_last      (m_rsp_last),
        .m_rsp_ready     (m_rsp_ready),
        .outstanding     (outstanding),
        .unmatched_count (unmatched_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Return just after a rising edge so the next stimulus starts mid-cycle.
    task automatic syncStep();
        @(posedge clk);
        #1;
    endtask

    task automatic applyAlloc(input int master, input int id);
        int waitCycles;
        alloc_valid  = 1'b1;
        alloc_master = 2'(master);
        alloc_id     = IDW'(id);
        waitCycles   = 0;
        @(negedge clk);
        while (!alloc_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("alloc_accept", 32'(alloc_ready), 32'd1);
        syncStep();
        alloc_valid = 1'b0;
    endtask

    // Drive one response beat; when it should be forwarded, queue the
    // expected delivery for the monitor.
    task automatic applyStimulus(input int id, input int resp, input int last, input bit fwd, input int master);
        int waitCycles;
        if (fwd) expQ.push_back('{master: master, id: id, resp: resp, last: last});
        rsp_valid  = 1'b1;
        rsp_id     = IDW'(id);
        rsp_resp   = 2'(resp);
        rsp_last   = 1'(last);
        waitCycles = 0;
        @(negedge clk);
        while (!rsp_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("rsp_accept", 32'(rsp_ready), 32'd1);
        syncStep();
        rsp_valid = 1'b0;
    endtask

    // A delivery is seen at the negedge before the edge that completes it.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (m_rsp_valid !== '0) checkOutput("onehot_valid", 32'($countones(m_rsp_valid)), 32'd1);
            for (int i = 0; i < NM; i++) begin
                if (m_rsp_valid[i] && m_rsp_ready[i]) begin
                    if (expQ.size() == 0) begin
                        assertCount++;
                        failCount++;
                        $display("[TB] FAIL unexpected_rsp: master %0d id %0h delivered, none expected", i, m_rsp_id);
                    end else begin
                        monExp = expQ.pop_front();
                        checkOutput("rsp_master", 32'(i), 32'(monExp.master));
                        checkOutput("rsp_id", 32'(m_rsp_id), 32'(monExp.id));
                        checkOutput("rsp_resp", 32'(m_rsp_resp), 32'(monExp.resp));
                        checkOutput("rsp_last", 32'(m_rsp_last), 32'(monExp.last));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_master = '0;
        alloc_id     = '0;
        rsp_valid    = 1'b0;
        rsp_id       = '0;
        rsp_resp     = '0;
        rsp_last     = 1'b0;
        m_rsp_ready  = '1;

        // Reset values
        @(negedge clk);
        checkOutput("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        checkOutput("rst_rsp_ready", 32'(rsp_ready), 32'd1);
        checkOutput("rst_m_valid", 32'(m_rsp_valid), 32'd0);
        checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
        checkOutput("rst_unmatched", unmatched_count, 32'd0);
        rst_n = 1'b1;
        syncStep();

        // Single allocate / response round trip
        applyAlloc(2, 5);
        @(negedge clk);
        checkOutput("rt_outstanding_1", 32'(outstanding), 32'd1);
        syncStep();
        applyStimulus(5, RESP_OKAY, 1, 1'b1, 2);
        @(negedge clk);
        checkOutput("rt_m_valid", 32'(m_rsp_valid), 32'b0100);
        checkOutput("rt_outstanding_0", 32'(outstanding), 32'd0);
        syncStep();

        // Unmatched response on an empty table
        applyStimulus(9, RESP_OKAY, 1, 1'b0, 0);
        @(negedge clk);
        checkOutput("unm_count", unmatched_count, 32'd1);
        checkOutput("unm_m_valid", 32'(m_rsp_valid), 32'd0);
        syncStep();

        // Fill the table, then free one slot
        for (int i = 0; i < TD; i++) applyAlloc(i % NM, i);
        alloc_id = 4'd12;
        @(negedge clk);
        checkOutput("full_outstanding", 32'(outstanding), 32'd8);
        checkOutput("full_alloc_ready", 32'(alloc_ready), 32'd0);
        syncStep();
        applyStimulus(3, RESP_SLVERR, 1, 1'b1, 3);
        @(negedge clk);
        checkOutput("freed_alloc_ready", 32'(alloc_ready), 32'd1);
        checkOutput("freed_outstanding", 32'(outstanding), 32'd7);
        syncStep();

        // Non-last beat keeps the entry, last beat frees it
        applyStimulus(6, RESP_EXOKAY, 0, 1'b1, 2);
        @(negedge clk);
        checkOutput("nonlast_outstanding", 32'(outstanding), 32'd7);
        syncStep();
        applyStimulus(6, RESP_OKAY, 1, 1'b1, 2);
        @(negedge clk);
        checkOutput("last_outstanding", 32'(outstanding), 32'd6);
        syncStep();

        // Back-to-back responses, one per cycle
        for (int k = 0; k < 3; k++) begin
            expQ.push_back('{master: k, id: k, resp: RESP_OKAY, last: 1});
            rsp_valid = 1'b1;
            rsp_id    = IDW'(k);
            rsp_resp  = RESP_OKAY;
            rsp_last  = 1'b1;
            @(negedge clk);
            checkOutput("b2b_ready", 32'(rsp_ready), 32'd1);
            syncStep();
        end
        rsp_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_outstanding", 32'(outstanding), 32'd3);
        syncStep();
        applyStimulus(5, RESP_OKAY, 1, 1'b1, 1);
        applyStimulus(7, RESP_DECERR, 1, 1'b1, 3);
        @(negedge clk);
        checkOutput("drain_outstanding", 32'(outstanding), 32'd1);
        syncStep();

        // Duplicate-ID stall: id 4 (master 0) still outstanding
        alloc_valid  = 1'b1;
        alloc_master = 2'd1;
        alloc_id     = 4'd4;
        @(negedge clk);
        checkOutput("dup_stall_0", 32'(alloc_ready), 32'd0);
        syncStep();
        expQ.push_back('{master: 0, id: 4, resp: RESP_OKAY, last: 1});
        rsp_valid = 1'b1;
        rsp_id    = 4'd4;
        rsp_resp  = RESP_OKAY;
        rsp_last  = 1'b1;
        @(negedge clk);
        checkOutput("dup_stall_1", 32'(alloc_ready), 32'd0);
        syncStep();
        rsp_valid = 1'b0;
        @(negedge clk);
        checkOutput("dup_release", 32'(alloc_ready), 32'd1);
        checkOutput("dup_outstanding_0", 32'(outstanding), 32'd0);
        syncStep();
        alloc_valid = 1'b0;
        @(negedge clk);
        checkOutput("dup_outstanding_1", 32'(outstanding), 32'd1);
        syncStep();

        // Simultaneous allocate (id 10) and free (id 4, now master 1)
        alloc_valid  = 1'b1;
        alloc_master = 2'd3;
        alloc_id     = 4'd10;
        expQ.push_back('{master: 1, id: 4, resp: RESP_OKAY, last: 1});
        rsp_valid = 1'b1;
        rsp_id    = 4'd4;
        rsp_resp  = RESP_OKAY;
        rsp_last  = 1'b1;
        @(negedge clk);
        checkOutput("same_alloc_ready", 32'(alloc_ready), 32'd1);
        checkOutput("same_rsp_ready", 32'(rsp_ready), 32'd1);
        syncStep();
        alloc_valid = 1'b0;
        rsp_valid   = 1'b0;
        @(negedge clk);
        checkOutput("same_outstanding", 32'(outstanding), 32'd1);
        syncStep();

        // Backpressure from master 1 for five cycles
        applyAlloc(1, 11);
        m_rsp_ready[1] = 1'b0;
        applyStimulus(11, RESP_DECERR, 0, 1'b1, 1);
        expQ.push_back('{master: 1, id: 11, resp: RESP_OKAY, last: 1});
        rsp_valid = 1'b1;
        rsp_id    = 4'd11;
        rsp_resp  = RESP_OKAY;
        rsp_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_m_valid", 32'(m_rsp_valid), 32'b0010);
            checkOutput("bp_id", 32'(m_rsp_id), 32'd11);
            checkOutput("bp_resp", 32'(m_rsp_resp), 32'd3);
            checkOutput("bp_last", 32'(m_rsp_last), 32'd0);
            checkOutput("bp_rsp_ready", 32'(rsp_ready), 32'd0);
            syncStep();
        end
        m_rsp_ready[1] = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", 32'(rsp_ready), 32'd1);
        syncStep();
        rsp_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_next_valid", 32'(m_rsp_valid), 32'b0010);
        checkOutput("bp_next_outstanding", 32'(outstanding), 32'd1);
        syncStep();

        // Reset with three entries outstanding and a held output
        applyAlloc(0, 12);
        applyAlloc(2, 13);
        m_rsp_ready[3] = 1'b0;
        applyStimulus(10, RESP_OKAY, 0, 1'b1, 3);
        @(negedge clk);
        checkOutput("pre_rst_m_valid", 32'(m_rsp_valid), 32'b1000);
        checkOutput("pre_rst_outstanding", 32'(outstanding), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_m_valid", 32'(m_rsp_valid), 32'd0);
        checkOutput("mid_rst_outstanding", 32'(outstanding), 32'd0);
        checkOutput("mid_rst_alloc_ready", 32'(alloc_ready), 32'd1);
        checkOutput("mid_rst_rsp_ready", 32'(rsp_ready), 32'd1);
        checkOutput("mid_rst_unmatched", unmatched_count, 32'd0);
        expQ.delete();
        m_rsp_ready = '1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("post_rst_m_valid", 32'(m_rsp_valid), 32'd0);
            checkOutput("post_rst_outstanding", 32'(outstanding), 32'd0);
        end

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
